// File: rtl/ghostbus_host_pkg.sv
// Shared types and constants for the ghostbus host initiator.
package ghostbus_host_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WSTB  = 2'd1,
    RSTB  = 2'd2,
    RWAIT = 2'd3
  } gb_state_e;

  // Depth of the read-response buffer.
  localparam int unsigned RESP_DEPTH = 2;

  // Width of the read-delay counter; RD is limited to 1..255.
  localparam int unsigned RD_W = 8;

endpackage

// File: rtl/gb_resp_fifo.sv
// Two-entry first-word-fall-through buffer holding {addr, rdata} read responses.
module gb_resp_fifo
  import ghostbus_host_pkg::*;
#(
  parameter int unsigned W = 56
) (
  input  logic         gb_clk,
  input  logic         gb_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [RESP_DEPTH];
  logic [W-1:0] mem_d [RESP_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'(RESP_DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ghostbus_host.sv
// Ghostbus initiator: turns a valid/ready command stream into single-cycle
// gb_wen/gb_rstb strobes and returns read data after the fixed read delay.
module ghostbus_host
  import ghostbus_host_pkg::*;
#(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32,
  parameter int unsigned RD = 8
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] resp_addr,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_wen,
  output logic          gb_rstb,
  input  logic [DW-1:0] gb_rdata
);

  gb_state_e       state_q, state_d;
  logic [RD_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   gb_addr_q, gb_addr_d;
  logic [DW-1:0]   gb_wdata_q, gb_wdata_d;
  logic            gb_wen_q, gb_wen_d;
  logic            gb_rstb_q, gb_rstb_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_count;
  logic [1:0]      fifo_count_nxt;
  logic [AW+DW-1:0] fifo_head;

  assign accept = cmd_valid && cmd_ready_q;
  assign pop    = resp_valid && resp_ready;

  // Sequencer: next state, counter, bus address/data and registered strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gb_addr_d  = gb_addr_q;
    gb_wdata_d = gb_wdata_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gb_addr_d = cmd_addr;
          if (cmd_we) begin
            gb_wdata_d = cmd_wdata;
            state_d    = WSTB;
          end else begin
            state_d = RSTB;
          end
        end
      end
      WSTB: begin
        state_d = IDLE;
      end
      RSTB: begin
        cnt_d   = RD_W'(RD - 1);
        state_d = RWAIT;
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          push    = !fifo_full;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes and cmd_ready are registered from the next state so they are
    // glitch-free and never combinational on cmd_valid; the buffer occupancy
    // is looked ahead so a pop frees the slot for the very next accept.
    case ({push, pop})
      2'b10:   fifo_count_nxt = fifo_count + 2'd1;
      2'b01:   fifo_count_nxt = fifo_count - 2'd1;
      default: fifo_count_nxt = fifo_count;
    endcase
    gb_wen_d    = (state_d == WSTB);
    gb_rstb_d   = (state_d == RSTB);
    cmd_ready_d = (state_d == IDLE) && (fifo_count_nxt < 2'(RESP_DEPTH));
  end

  // Sequencer state registers.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gb_addr_q   <= '0;
      gb_wdata_q  <= '0;
      gb_wen_q    <= 1'b0;
      gb_rstb_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gb_addr_q   <= gb_addr_d;
      gb_wdata_q  <= gb_wdata_d;
      gb_wen_q    <= gb_wen_d;
      gb_rstb_q   <= gb_rstb_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  gb_resp_fifo #(
    .W(AW + DW)
  ) u_resp_fifo (
    .gb_clk    (gb_clk),
    .gb_rst    (gb_rst),
    .push      (push),
    .push_data ({gb_addr_q, gb_rdata}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready  = cmd_ready_q;
  assign busy       = (state_q != IDLE);
  assign gb_addr    = gb_addr_q;
  assign gb_wdata   = gb_wdata_q;
  assign gb_wen     = gb_wen_q;
  assign gb_rstb    = gb_rstb_q;
  assign resp_valid = !fifo_empty;
  assign resp_addr  = fifo_head[AW+DW-1:DW];
  assign resp_rdata = fifo_head[DW-1:0];

endmodule
